// File: rtl/checkers_move_engine.sv
// Checkers rules engine: board storage, per-piece legal move slots, turn FSM.
// Cells are indexed by loc = {x, y} and hold {occupied, red, king}.
module checkers_move_engine #(
   parameter int COORD_W      = 3,
   parameter int INIT_ROWS    = 3,
   parameter bit FIRST_PLAYER = 1'b1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   select_valid,
   input  logic [2*COORD_W-1:0]                   select_loc,
   input  logic                                   load_en,
   input  logic [2*COORD_W-1:0]                   load_loc,
   input  logic [2:0]                             load_piece,
   output logic [4*(2*COORD_W+2)-1:0]             legal_move,
   output logic [3*(2**COORD_W)*(2**COORD_W)-1:0] serialized_board,
   output logic                                   player_turn,
   output logic [7:0]                             turn_count,
   output logic [2*COORD_W-1:0]                   red_count,
   output logic [2*COORD_W-1:0]                   white_count,
   output logic                                   game_over,
   output logic                                   winner
);

   localparam int N     = 2**COORD_W;
   localparam int LW    = 2*COORD_W;
   localparam int SW    = LW+2;
   localparam int CELLS = N*N;

   typedef logic [CELLS-1:0][2:0]    board_t;
   typedef logic [LW-1:0]            loc_t;
   typedef logic [COORD_W-1:0]       coord_t;
   typedef logic [3:0][SW-1:0]       slots_t;
   typedef logic signed [COORD_W+1:0] crd_t;

   typedef enum logic [2:0] {
      PIECE_SELECT, MOVE_SELECT, CHAIN, SWITCH, GAME_OVER
   } state_t;

   localparam crd_t   ONE      = crd_t'(1);
   localparam crd_t   TWO      = crd_t'(2);
   localparam coord_t C1       = coord_t'(1);
   localparam loc_t   CNT_ONE  = loc_t'(1);
   localparam loc_t   INIT_CNT = loc_t'(INIT_ROWS*N/2);

   function automatic board_t init_board();
      board_t b;
      loc_t   idx;
      int     y;
      b = '0;
      for (int i = 0; i < CELLS; i++) begin
         idx = i[LW-1:0];
         y   = int'(idx[COORD_W-1:0]);
         if (idx[COORD_W] == idx[0]) begin
            if (y < INIT_ROWS)           b[idx] = 3'b110;
            else if (y >= N - INIT_ROWS) b[idx] = 3'b100;
         end
      end
      return b;
   endfunction

   localparam board_t INIT_B = init_board();

   // {in_bounds, loc} of the square one or two steps along slot k
   function automatic logic [LW:0] target(input loc_t loc, input int k,
                                          input logic two);
      crd_t x, y, d;
      d = two ? TWO : ONE;
      x = crd_t'({2'b00, loc[LW-1:COORD_W]});
      y = crd_t'({2'b00, loc[COORD_W-1:0]});
      x = (k % 2 == 1) ? x + d : x - d;
      y = (k < 2) ? y + d : y - d;
      return {(x[COORD_W+1:COORD_W] == 2'b00) &&
              (y[COORD_W+1:COORD_W] == 2'b00),
              x[COORD_W-1:0], y[COORD_W-1:0]};
   endfunction

   function automatic logic fwd_ok(input logic [2:0] p, input int k);
      return p[2] && (p[0] || (p[1] ? (k < 2) : (k >= 2)));
   endfunction

   function automatic logic [3:0] move_mask(input board_t b, input loc_t loc);
      logic [3:0]  m;
      logic [LW:0] a;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         a    = target(loc, k, 1'b0);
         m[k] = fwd_ok(b[loc], k) && a[LW] && !b[a[LW-1:0]][2];
      end
      return m;
   endfunction

   function automatic logic [3:0] jump_mask(input board_t b, input loc_t loc);
      logic [3:0]  m;
      logic [LW:0] a, j;
      m = '0;
      for (int k = 0; k < 4; k++) begin
         a    = target(loc, k, 1'b0);
         j    = target(loc, k, 1'b1);
         m[k] = fwd_ok(b[loc], k) && a[LW] && j[LW] &&
                b[a[LW-1:0]][2] &&
                (b[a[LW-1:0]][1] != b[loc][1]) &&
                !b[j[LW-1:0]][2];
      end
      return m;
   endfunction

   function automatic slots_t gen_moves(input board_t b, input loc_t loc);
      slots_t      s;
      logic [3:0]  mm, jm;
      logic [LW:0] a, j;
      s  = '0;
      mm = move_mask(b, loc);
      jm = jump_mask(b, loc);
      for (int k = 0; k < 4; k++) begin
         a = target(loc, k, 1'b0);
         j = target(loc, k, 1'b1);
         if (|jm) begin
            if (jm[k] && j[LW]) s[k] = {2'b11, j[LW-1:0]};
         end else if (mm[k] && a[LW]) begin
            s[k] = {2'b10, a[LW-1:0]};
         end
      end
      return s;
   endfunction

   state_t     state_q, state_d;
   board_t     board_q, board_d;
   loc_t       sel_q, sel_d;
   logic       turn_q, turn_d;
   logic [7:0] cnt_q, cnt_d;
   loc_t       red_q, red_d;
   loc_t       white_q, white_d;
   logic       winner_q, winner_d;

   slots_t     cur_s;
   logic [3:0] hit;
   logic       is_jump, kinged, far_row;
   logic [2:0] piece;
   coord_t     mid_x, mid_y;
   loc_t       mid;

   assign cur_s   = gen_moves(board_q, sel_q);
   assign piece   = board_q[sel_q];
   assign far_row = piece[1] ? (&select_loc[COORD_W-1:0])
                             : ~(|select_loc[COORD_W-1:0]);
   assign kinged  = far_row && !piece[0];

   assign mid_x = (select_loc[LW-1:COORD_W] > sel_q[LW-1:COORD_W]) ?
                  sel_q[LW-1:COORD_W] + C1 : sel_q[LW-1:COORD_W] - C1;
   assign mid_y = (select_loc[COORD_W-1:0] > sel_q[COORD_W-1:0]) ?
                  sel_q[COORD_W-1:0] + C1 : sel_q[COORD_W-1:0] - C1;
   assign mid   = {mid_x, mid_y};

   always_comb begin
      hit     = '0;
      is_jump = 1'b0;
      for (int k = 0; k < 4; k++) begin
         hit[k] = cur_s[k][SW-1] &&
                  (cur_s[k][LW-1:0] == select_loc) &&
                  (state_q != CHAIN || cur_s[k][SW-2]);
         if (hit[k]) is_jump = cur_s[k][SW-2];
      end
   end

   always_comb begin
      state_d  = state_q;
      board_d  = board_q;
      sel_d    = sel_q;
      turn_d   = turn_q;
      cnt_d    = cnt_q;
      winner_d = winner_q;
      unique case (state_q)
         PIECE_SELECT: begin
            if (load_en) begin
               board_d[load_loc] = load_piece;
            end else if (select_valid && board_q[select_loc][2] &&
                         (board_q[select_loc][1] == turn_q) &&
                         |(move_mask(board_q, select_loc) |
                           jump_mask(board_q, select_loc))) begin
               sel_d   = select_loc;
               state_d = MOVE_SELECT;
            end
         end
         MOVE_SELECT, CHAIN: begin
            if (select_valid && |hit) begin
               board_d[sel_q]      = '0;
               board_d[select_loc] = {piece[2:1], piece[0] | kinged};
               if (is_jump) board_d[mid] = '0;
               sel_d = select_loc;
               // a man crowned by this jump ends the turn even if more captures exist
               if (is_jump && !kinged &&
                   |jump_mask(board_d, select_loc))
                  state_d = CHAIN;
               else
                  state_d = SWITCH;
            end else if (select_valid && state_q == MOVE_SELECT) begin
               state_d = PIECE_SELECT;
            end
         end
         SWITCH: begin
            turn_d = ~turn_q;
            if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
            if ((turn_q ? white_q : red_q) == '0) begin
               state_d  = GAME_OVER;
               winner_d = turn_q;
            end else begin
               state_d = PIECE_SELECT;
            end
         end
         GAME_OVER: ;
         default: state_d = PIECE_SELECT;
      endcase
   end

   always_comb begin
      red_d   = '0;
      white_d = '0;
      for (int i = 0; i < CELLS; i++) begin
         if (board_d[i[LW-1:0]][2]) begin
            if (board_d[i[LW-1:0]][1]) red_d = red_d + CNT_ONE;
            else white_d = white_d + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= PIECE_SELECT;
         board_q  <= INIT_B;
         sel_q    <= '0;
         turn_q   <= FIRST_PLAYER;
         cnt_q    <= '0;
         red_q    <= INIT_CNT;
         white_q  <= INIT_CNT;
         winner_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         board_q  <= board_d;
         sel_q    <= sel_d;
         turn_q   <= turn_d;
         cnt_q    <= cnt_d;
         red_q    <= red_d;
         white_q  <= white_d;
         winner_q <= winner_d;
      end
   end

   assign legal_move       = (state_q == MOVE_SELECT || state_q == CHAIN) ?
                             cur_s : '0;
   assign serialized_board = board_q;
   assign player_turn      = turn_q;
   assign turn_count       = cnt_q;
   assign red_count        = red_q;
   assign white_count      = white_q;
   assign game_over        = (state_q == GAME_OVER);
   assign winner           = winner_q;

endmodule

// File: tb/tb_checkers_move_engine.sv
// Directed bench for checkers_move_engine: 8x8 default board plus a 4x4
// instance for kinging and win detection.
module tb_checkers_move_engine;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic         sv8, le8;
   logic [5:0]   sl8, ll8;
   logic [2:0]   lp8;
   logic [31:0]  lm8;
   logic [191:0] bd8;
   logic         pt8, go8, wn8;
   logic [7:0]   tc8;
   logic [5:0]   rc8, wc8;

   logic         sv4, le4;
   logic [3:0]   sl4, ll4;
   logic [2:0]   lp4;
   logic [23:0]  lm4;
   logic [47:0]  bd4;
   logic         pt4, go4, wn4;
   logic [7:0]   tc4;
   logic [3:0]   rc4, wc4;

   int checks = 0;
   int errors = 0;

   checkers_move_engine dut8 (
      .clk(clk), .rst(rst),
      .select_valid(sv8), .select_loc(sl8),
      .load_en(le8), .load_loc(ll8), .load_piece(lp8),
      .legal_move(lm8), .serialized_board(bd8),
      .player_turn(pt8), .turn_count(tc8),
      .red_count(rc8), .white_count(wc8),
      .game_over(go8), .winner(wn8)
   );

   checkers_move_engine #(
      .COORD_W(2), .INIT_ROWS(1), .FIRST_PLAYER(1'b1)
   ) dut4 (
      .clk(clk), .rst(rst),
      .select_valid(sv4), .select_loc(sl4),
      .load_en(le4), .load_loc(ll4), .load_piece(lp4),
      .legal_move(lm4), .serialized_board(bd4),
      .player_turn(pt4), .turn_count(tc4),
      .red_count(rc4), .white_count(wc4),
      .game_over(go4), .winner(wn4)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] c8(input logic [5:0] loc);
      logic [63:0][2:0] b;
      b = bd8;
      return b[loc];
   endfunction

   function automatic logic [2:0] c4(input logic [3:0] loc);
      logic [15:0][2:0] b;
      b = bd4;
      return b[loc];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sel8(input logic [5:0] loc);
      sv8 = 1'b1; sl8 = loc;
      tick();
      sv8 = 1'b0;
   endtask

   task automatic ld8(input logic [5:0] loc, input logic [2:0] p);
      le8 = 1'b1; ll8 = loc; lp8 = p;
      tick();
      le8 = 1'b0;
   endtask

   task automatic sel4(input logic [3:0] loc);
      sv4 = 1'b1; sl4 = loc;
      tick();
      sv4 = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

   task automatic chain_setup();
      do_reset();
      for (int i = 0; i < 64; i++) ld8(6'(i), 3'b000);
      ld8(6'o11, 3'b110);
      ld8(6'o22, 3'b100);
      ld8(6'o44, 3'b100);
   endtask

   initial begin
      rst = 1'b0;
      sv8 = 0; le8 = 0; sl8 = '0; ll8 = '0; lp8 = '0;
      sv4 = 0; le4 = 0; sl4 = '0; ll4 = '0; lp4 = '0;
      tick();
      chk("rst_red", rc8, 12);
      chk("rst_white", wc8, 12);
      chk("rst_turn", pt8, 1);
      tick();
      rst = 1'b1;
      chk("rst_cnt", tc8, 0);
      chk("rst_c00", c8(6'o00), 3'b110);
      chk("rst_c15", c8(6'o15), 3'b100);
      chk("rst_c10", c8(6'o10), 3'b000);
      chk("rst_lm", lm8, 0);
      chk("rst_go", go8, 0);
      chk("rst_win", wn8, 0);
      chk("rst4_red", rc4, 2);
      chk("rst4_c20", c4(4'b1000), 3'b110);

      sel8(6'o15);
      chk("pick_opp", lm8, 0);
      sel8(6'o00);
      chk("pick_blocked", lm8, 0);

      sel8(6'o22);
      chk("simple_slots", lm8, 32'h0000_9B8B);
      sel8(6'o44);
      chk("deselect", lm8, 0);
      sel8(6'o22);
      sel8(6'o33);
      chk("mv_dst", c8(6'o33), 3'b110);
      chk("mv_src", c8(6'o22), 3'b000);
      chk("mv_turn_hold", pt8, 1);
      chk("mv_lm_switch", lm8, 0);
      tick();
      chk("mv_turn", pt8, 0);
      chk("mv_cnt", tc8, 1);

      sel8(6'o55);
      chk("white_slots", lm8, 32'hB4A4_0000);
      sel8(6'o44);
      tick();
      chk("w_turn", pt8, 1);
      sel8(6'o33);
      chk("forced_jump", lm8, 32'h0000_ED00);
      sel8(6'o55);
      chk("fj_cap", c8(6'o44), 3'b000);
      chk("fj_dst", c8(6'o55), 3'b110);
      chk("fj_white", wc8, 11);
      chk("fj_red", rc8, 12);
      tick();
      chk("fj_turn", pt8, 0);
      chk("fj_cnt", tc8, 3);
      chk("fj_go", go8, 0);

      chain_setup();
      chk("pre_red", rc8, 1);
      chk("pre_white", wc8, 2);
      sel8(6'o11);
      chk("mj_slots", lm8, 32'h0000_DB00);
      sel8(6'o33);
      chk("mj_chain", lm8, 32'h0000_ED00);
      chk("mj_cap1", c8(6'o22), 3'b000);
      chk("mj_white1", wc8, 1);
      sel8(6'o02);
      chk("mj_ignore", lm8, 32'h0000_ED00);
      chk("mj_hold", c8(6'o33), 3'b110);
      sel8(6'o55);
      chk("mj_white0", wc8, 0);
      chk("mj_dst", c8(6'o55), 3'b110);
      tick();
      chk("mj_go", go8, 1);
      chk("mj_win", wn8, 1);
      chk("mj_cnt", tc8, 1);
      ld8(6'o00, 3'b100);
      sel8(6'o55);
      chk("go_load", c8(6'o00), 3'b000);
      chk("go_white", wc8, 0);
      chk("go_lm", lm8, 0);
      chk("go_hold", go8, 1);

      chain_setup();
      sel8(6'o11);
      sel8(6'o33);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_red", rc8, 12);
      chk("arst_white", wc8, 12);
      chk("arst_turn", pt8, 1);
      chk("arst_lm", lm8, 0);
      chk("arst_c00", c8(6'o00), 3'b110);
      chk("arst_c33", c8(6'o33), 3'b000);
      @(posedge clk);
      #1;
      rst = 1'b1;

      sel4(4'b1000);
      chk("k_slots", lm4, 24'h000B65);
      sel4(4'b1101);
      tick();
      sel4(4'b0111);
      sel4(4'b1010);
      tick();
      sel4(4'b1101);
      chk("k_jump", lm4, 24'h000037);
      sel4(4'b0111);
      chk("k_king", c4(4'b0111), 3'b111);
      chk("k_cap", c4(4'b1010), 3'b000);
      chk("k_white", wc4, 1);
      tick();
      chk("k_turn", pt4, 0);
      chk("k_cnt", tc4, 3);
      sel4(4'b1111);
      sel4(4'b1010);
      tick();
      sel4(4'b0111);
      chk("k_back", lm4, 24'hF40000);
      sel4(4'b1101);
      chk("k_land", c4(4'b1101), 3'b111);
      chk("k_white0", wc4, 0);
      tick();
      chk("k_go", go4, 1);
      chk("k_win", wn4, 1);
      chk("k_cnt5", tc4, 5);
      chk("k_red", rc4, 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/checkers_move_engine.md
Name: checkers_move_engine

Overview:
Parametrised checkers rules engine: holds the board, generates per-piece legal moves, and runs the turn FSM. Supports simple moves, captures (jumps), multi-jump chains, kinging and win detection. Sits between the select/cursor input logic and the VGA board renderer, which consumes serialized_board. A preload port lets benches and puzzle modes write arbitrary positions.

Parameters:
COORD_W, 3, coordinate width; board side N = 2**COORD_W; loc = {x[COORD_W-1:0], y[COORD_W-1:0]}
INIT_ROWS, 3, rows per side filled at reset (1..N/2-1)
FIRST_PLAYER, 1, player to move after reset (1 = red)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
select_valid  in  1  one-cycle strobe qualifying select_loc
select_loc  in  2*COORD_W  square picked by the player
load_en  in  1  preload write strobe; honoured only in PIECE_SELECT
load_loc  in  2*COORD_W  preload square
load_piece  in  3  preload value {occupied, red, king}
legal_move  out  4*(2*COORD_W+2)  four slots, each {valid, jump, loc}
serialized_board  out  3*N*N  cell i at [3i+2:3i]
player_turn  out  1  1 = red to move
turn_count  out  8  completed turns, saturates at 255
red_count  out  COORD_W*2  red pieces on board
white_count  out  COORD_W*2  white pieces on board
game_over  out  1  high in GAME_OVER
winner  out  1  valid when game_over; 1 = red

Behaviour:
- Piece code {occupied, red, king}. Red advances toward +y, white toward -y; kings move both ways.
- Slot order: slot0 (-x,+y), slot1 (+x,+y), slot2 (-x,-y), slot3 (+x,-y).
- Reset values:
  - Dark squares are those with x+y even. Red occupies them for y<INIT_ROWS; white for y>=N-INIT_ROWS; all other cells are 0.
  - Counts = INIT_ROWS*N/2 each; player_turn = FIRST_PLAYER; turn_count = 0; game_over = 0; winner = 0; FSM = PIECE_SELECT; legal_move = 0.
- Move generation (combinational from registered sel_loc and board):
  - A slot is a simple move if the adjacent diagonal is in bounds and empty.
  - A slot is a jump if the adjacent diagonal holds an opponent piece and the square beyond is in bounds and empty.
  - If any slot of the piece is a jump, only jump slots are valid.
  - legal_move is 0 outside MOVE_SELECT and CHAIN.
- FSM states: PIECE_SELECT, MOVE_SELECT, CHAIN, SWITCH, GAME_OVER.
  - PIECE_SELECT: on select_valid of an own piece with at least one valid slot, latch sel_loc and go to MOVE_SELECT. Otherwise stay.
  - PIECE_SELECT, load_en: write board[load_loc] and recompute the colour counts at the same edge. A simultaneous select_valid is ignored.
  - MOVE_SELECT: select_valid matching a valid slot commits at that edge. The commit moves the piece, clears the origin, clears the captured square on a jump (decrementing the opponent count), and sets king if the piece lands on the far row (red y=N-1, white y=0).
  - MOVE_SELECT, next state after commit: CHAIN if it was a jump, not newly kinged, and the landed piece has another jump (sel_loc follows the piece). Otherwise SWITCH.
  - MOVE_SELECT: select_valid on any non-matching square returns to PIECE_SELECT with no board change.
  - CHAIN: only jumps are valid. Non-matching selects are ignored (no deselect). Commit follows the MOVE_SELECT rules.
  - SWITCH (one cycle): toggle player_turn; turn_count += 1 (saturating). If the opponent count is 0, go to GAME_OVER with winner = mover. Otherwise go to PIECE_SELECT.
  - GAME_OVER: ignore all selects and loads until reset.
- select_valid and load_en are ignored in SWITCH.
- Reset mid-chain or mid-turn restores the initial position immediately (asynchronous).

Test Plan:
- Reset (defaults) -> red_count=12, white_count=12, turn_count=0, player_turn=1. Cell (0,0)=3'b110, cell (1,5)=3'b100, all other outputs 0.
- Simple move: select loc 18 (2,2) -> slot0={1,0,(1,3)}, slot1={1,0,(3,3)}. Then select 27 -> board(3,3)=110, (2,2)=0; player_turn=0, turn_count=1 two cycles later.
- Forced jump:
  - Sequence: red (2,2)->(3,3), white (5,5)->(4,4), then select (3,3).
  - Expected: slot1={1,1,(5,5)} and slot0 invalid.
  - Commit: (4,4) cleared, white_count=11, no chain, player_turn=0.
- Multi-jump: preload red man (1,1), white men (2,2) and (4,4), all else empty. Select (1,1) then (3,3) -> state CHAIN, a select of (0,2) is ignored. Select (5,5) -> white_count=0, then GAME_OVER, winner=1.
- King and win, COORD_W=2, INIT_ROWS=1:
  - Moves: red (2,0)->(3,1); white (1,3)->(2,2); red (3,1)x(2,2) to (1,3).
  - After the capture: cell = 3'b111, turn ends, white_count=1.
  - Then: white (3,3)->(2,2); red king (1,3)x(2,2) to (3,1).
  - Expected: game_over=1, winner=1, turn_count=5.
- Reset asserted while in CHAIN -> next sampled outputs equal the reset values. A select_valid or load_en in GAME_OVER -> no change.
